adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_scheduler_if.sv | 44 ++++
 rtl/adder_scheduler.sv | 170 +++++++++++++++++
 tb/tb_adder_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_scheduler_if
// Description : Bundles the requester, response and shared-adder signals of
//               adder_scheduler.
//               slave  - used by the scheduler itself.
//               master - used by the environment (requesters plus the adder).
//               Requester i owns slice [i*SIZE +: SIZE] of req_a/req_b.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_scheduler_if #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*SIZE-1:0] req_a;
    logic [NUM_REQ*SIZE-1:0] req_b;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [NUM_REQ-1:0]      rsp_ready;
    logic [SIZE-1:0]         rsp_sum;
    logic                    rsp_carry;
    logic                    add_start;
    logic [SIZE-1:0]         add_a;
    logic [SIZE-1:0]         add_b;
    logic [SIZE-1:0]         add_sum;
    logic                    add_carry;
    logic                    add_done;
    logic                    busy;
    logic                    timeout_err;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_sum, add_carry, add_done,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, add_start, add_a, add_b,
               busy, timeout_err
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_sum, add_carry, add_done,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, add_start, add_a, add_b,
               busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adder_scheduler
// Description : Round-robin scheduler sharing one sequential adder among
//               NUM_REQ requesters. One transaction at a time:
//               IDLE (grant) -> LOAD (add_start pulse) -> RUN (wait add_done)
//               -> RESP (hold result until the owner accepts it).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               bus (slave)       - req_valid/req_ready/req_a/req_b,
//                                   rsp_valid/rsp_ready/rsp_sum/rsp_carry,
//                                   add_start/add_a/add_b, add_sum/add_carry/
//                                   add_done, busy, timeout_err
// Options     : ADDER_SCHEDULER_WATCHDOG_EN - RUN watchdog; after SIZE+3 RUN
//               cycles without add_done the result is forced to zero and
//               timeout_err is set until reset. Undefined: RUN waits forever
//               and timeout_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_scheduler #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4
) (
    input wire logic         clk,
    input wire logic         rst,
    adder_scheduler_if.slave bus
);
    localparam int                   c_idx_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_idx_w-1:0]   c_last_rst = c_idx_w'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   c_one      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_idx_w-1:0]  last_grant_q, last_grant_d;
    logic [SIZE-1:0]     add_a_q, add_a_d;
    logic [SIZE-1:0]     add_b_q, add_b_d;
    logic [SIZE-1:0]     rsp_sum_q, rsp_sum_d;
    logic                rsp_carry_q, rsp_carry_d;

    logic [c_idx_w-1:0]  w_winner;
    logic                w_found;
    logic                w_wd_expire;

    // Round-robin search: start one past the last grant and wrap, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && bus.req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = c_idx_w'((int'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_carry_d  = rsp_carry_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d      = LOAD;
                    last_grant_d = w_winner;
                    add_a_d      = bus.req_a[int'(w_winner)*SIZE +: SIZE];
                    add_b_d      = bus.req_b[int'(w_winner)*SIZE +: SIZE];
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (bus.add_done) begin
                    state_d     = RESP;
                    rsp_sum_d   = bus.add_sum;
                    rsp_carry_d = bus.add_carry;
                end else if (w_wd_expire) begin
                    state_d     = RESP;
                    rsp_sum_d   = '0;
                    rsp_carry_d = 1'b0;
                end
            end
            RESP: begin
                // Only the owner's rsp_ready can close the response.
                if (bus.rsp_ready[last_grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= c_last_rst;
            add_a_q      <= '0;
            add_b_q      <= '0;
            rsp_sum_q    <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

`ifdef ADDER_SCHEDULER_WATCHDOG_EN
    localparam int                 c_cnt_w = $clog2(SIZE + 3);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SIZE + 2);

    logic [c_cnt_w-1:0] run_cnt_q, run_cnt_d;
    logic               timeout_q, timeout_d;

    // run_cnt counts completed RUN cycles; it equals SIZE+2 during the
    // (SIZE+3)-th RUN cycle, which is the last one allowed.
    assign w_wd_expire = (run_cnt_q == c_cnt_last);

    always_comb begin
        run_cnt_d = run_cnt_q;
        timeout_d = timeout_q;
        if (state_q == LOAD) begin
            run_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (!w_wd_expire) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
            if (!bus.add_done && w_wd_expire) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign w_wd_expire     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Grants are suppressed while rst is high so reset wins over req_valid.
    assign bus.req_ready = (state_q == IDLE && !rst && w_found) ? (c_one << w_winner) : '0;
    assign bus.rsp_valid = (state_q == RESP) ? (c_one << last_grant_q) : '0;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.add_start = (state_q == LOAD);
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_scheduler
// Description : Self-checking bench for adder_scheduler. Contains a model of
//               the shared sequential adder (XOR/AND iterations, one per
//               cycle), a transaction-level model of the scheduler checked on
//               every negative edge, and directed tests with literal results.
//               Define ADDER_SCHEDULER_WATCHDOG_EN to include the watchdog test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_scheduler;
    localparam int SIZE    = 8;
    localparam int NUM_REQ = 4;
    localparam int P_IDLE  = 0;
    localparam int P_WORK  = 1;
    localparam int P_RESP  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_scheduler_if #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) bus ();

    adder_scheduler #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of XOR/AND iterations the sequential adder needs; the carry
    // out of the top bit still costs one final iteration.
    function automatic int iters(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [SIZE-1:0] x;
        logic [SIZE-1:0] t;
        logic [SIZE:0]   y;
        int              n;
        x = a;
        y = {1'b0, b};
        n = 0;
        do begin
            t = x ^ y[SIZE-1:0];
            y = {1'b0, x & y[SIZE-1:0]} << 1;
            x = t;
            n++;
        end while (y != '0);
        return n;
    endfunction

    // ---------------- shared adder model ----------------
    int            ad_left   = 0;
    logic [SIZE:0] ad_res    = '0;
    logic          kill_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ad_left <= 0;
        end else if (bus.add_start) begin
            ad_left <= iters(bus.add_a, bus.add_b);
            ad_res  <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
        end else if (ad_left != 0) begin
            ad_left <= ad_left - 1;
        end
    end

    assign bus.add_done  = (ad_left == 1) && !kill_done;
    assign bus.add_sum   = ad_res[SIZE-1:0];
    assign bus.add_carry = ad_res[SIZE];

    // ---------------- scheduler model and per-cycle compare ----------------
    int              m_phase   = P_IDLE;
    int              m_last    = NUM_REQ - 1;
    int              m_owner   = 0;
    int              m_since   = 0;
    int              m_n       = 0;
    logic [SIZE-1:0] m_a       = '0;
    logic [SIZE-1:0] m_b       = '0;
    logic [SIZE:0]   m_res     = '0;
    logic            m_to      = 1'b0;
    logic            m_to_pend = 1'b0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_rsp;
        int                 w;
        exp_ready = '0;
        exp_rsp   = '0;
        w         = -1;
        if (!rst && m_phase == P_IDLE) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (bus.req_valid[(m_last + k) % NUM_REQ]) begin
                    w = (m_last + k) % NUM_REQ;
                    break;
                end
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        if (m_phase == P_RESP) exp_rsp[m_owner] = 1'b1;

        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        check("busy", 32'(bus.busy), 32'(m_phase != P_IDLE));
        check("add_start", 32'(bus.add_start), 32'(m_phase == P_WORK && m_since == 1));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_to));
        if (m_phase == P_WORK && m_since == 1) begin
            check("add_a", 32'(bus.add_a), 32'(m_a));
            check("add_b", 32'(bus.add_b), 32'(m_b));
        end
        if (m_phase == P_RESP) begin
            check("rsp_sum", 32'(bus.rsp_sum), 32'(m_res[SIZE-1:0]));
            check("rsp_carry", 32'(bus.rsp_carry), 32'(m_res[SIZE]));
        end

        // advance the model to the state after the coming rising edge
        if (rst) begin
            m_phase = P_IDLE;
            m_last  = NUM_REQ - 1;
            m_to    = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (w >= 0) begin
                        m_owner = w;
                        m_last  = w;
                        m_a     = bus.req_a[w*SIZE +: SIZE];
                        m_b     = bus.req_b[w*SIZE +: SIZE];
                        m_since = 1;
                        if (kill_done) begin
                            m_n       = SIZE + 3;
                            m_res     = '0;
                            m_to_pend = 1'b1;
                        end else begin
                            m_n       = iters(m_a, m_b);
                            m_res     = {1'b0, m_a} + {1'b0, m_b};
                            m_to_pend = 1'b0;
                        end
                        m_phase = P_WORK;
                    end
                end
                P_WORK: begin
                    m_since++;
                    if (m_since == m_n + 2) begin
                        m_phase = P_RESP;
                        if (m_to_pend) m_to = 1'b1;
                    end
                end
                default: begin
                    if (bus.rsp_ready[m_owner]) m_phase = P_IDLE;
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_bit(input string name, input int idx, input bit want_rsp);
        int t;
        t = 0;
        @(negedge clk);
        while (!(want_rsp ? bus.rsp_valid[idx] : bus.req_ready[idx]) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(want_rsp ? bus.rsp_valid[idx] : bus.req_ready[idx]), 32'd1);
    endtask

    // One request from requester idx. lat = edges from accept to rsp_valid.
    // hold > 0 keeps rsp_ready low that many cycles while the other
    // requesters assert req_valid and rsp_ready.
    task automatic txn(input int idx, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       input int hold, output int lat, output logic [SIZE-1:0] s,
                       output logic c);
        int acc;
        @(posedge clk); #1;
        bus.req_a[idx*SIZE +: SIZE] = a;
        bus.req_b[idx*SIZE +: SIZE] = b;
        bus.req_valid[idx]          = 1'b1;
        wait_bit($sformatf("accept_req%0d", idx), idx, 1'b0);
        acc = cyc + 1;
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
        wait_bit($sformatf("rsp_req%0d", idx), idx, 1'b1);
        lat = cyc - acc;
        s   = bus.rsp_sum;
        c   = bus.rsp_carry;
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.req_valid = ~(NUM_REQ'(1) << idx);
            bus.rsp_ready = ~(NUM_REQ'(1) << idx);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_no_req_ready", 32'(bus.req_ready), 32'd0);
                check("hold_rsp_valid", 32'(bus.rsp_valid[idx]), 32'd1);
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = NUM_REQ'(1) << idx;
        @(posedge clk); #1;
        bus.rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int              lat;
        logic [SIZE-1:0] s;
        logic            c;
        int              gidx;
        int              exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        check("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
        check("rst_add_start", 32'(bus.add_start), 32'd0);
        check("rst_add_a", 32'(bus.add_a), 32'd0);
        check("rst_add_b", 32'(bus.add_b), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout", 32'(bus.timeout_err), 32'd0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.req_valid = '0;

        // 0x00 + 0x5A: one adder iteration, result two edges after accept
        txn(2, 8'h00, 8'h5A, 0, lat, s, c);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_sum", 32'(s), 32'h5A);
        check("t1_carry", 32'(c), 32'd0);

        // 0xFF + 0x01: carry ripples through all bits, 9 RUN cycles
        txn(1, 8'hFF, 8'h01, 0, lat, s, c);
        check("t2_latency", 32'(lat), 32'd10);
        check("t2_sum", 32'(s), 32'h00);
        check("t2_carry", 32'(c), 32'd1);

        // response held for 5 cycles, other requesters pushing meanwhile
        txn(0, 8'h3C, 8'h11, 5, lat, s, c);
        check("t3_sum", 32'(s), 32'h4D);
        check("t3_carry", 32'(c), 32'd0);

        // reset in the middle of RUN for requester 1
        @(posedge clk); #1;
        bus.req_a[1*SIZE +: SIZE] = 8'hFF;
        bus.req_b[1*SIZE +: SIZE] = 8'h01;
        bus.req_valid[1]          = 1'b1;
        wait_bit("t5_accept", 1, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy_after_rst", 32'(bus.busy), 32'd0);
        check("t5_rsp_valid_after_rst", 32'(bus.rsp_valid), 32'd0);

        // all four requesters held: grants 0,1,2,3,0
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*SIZE +: SIZE] = 8'(i * 16 + 1);
            bus.req_b[i*SIZE +: SIZE] = 8'h22;
        end
        bus.rsp_ready = '1;
        bus.req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (bus.req_ready == '0 && t < 40) begin
                @(negedge clk);
                t++;
            end
            check("rr_grant_seen", 32'(|bus.req_ready), 32'd1);
            check("rr_onehot", 32'($onehot(bus.req_ready)), 32'd1);
            gidx = -1;
            for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gidx = i;
            check($sformatf("rr_order_%0d", g), 32'(gidx), 32'(exp_order[g]));
            @(posedge clk); #1;
            if (g == 4) bus.req_valid = '0;
        end
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (bus.busy && t < 40) begin
                @(negedge clk);
                t++;
            end
            check("rr_drain", 32'(bus.busy), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = '0;

`ifdef ADDER_SCHEDULER_WATCHDOG_EN
        // adder never finishes: forced zero result after 11 RUN cycles
        kill_done = 1'b1;
        txn(2, 8'h12, 8'h34, 0, lat, s, c);
        check("wd_latency", 32'(lat), 32'd12);
        check("wd_sum", 32'(s), 32'd0);
        check("wd_carry", 32'(c), 32'd0);
        kill_done = 1'b0;
        repeat (3) @(negedge clk);
        check("wd_sticky", 32'(bus.timeout_err), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("wd_cleared", 32'(bus.timeout_err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
